// File: rtl/bt_pkg.sv
// rtl/bt_pkg.sv - shared types and constants for the branch table update path
package bt_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bt_state_e;

  localparam int INDEX_W = 4;
  localparam int TAG_W   = 26;
  localparam logic [TAG_W-1:0] INV_TAG = 26'h3FFFFFF;

  // One pending table write: address, target, prediction bit and enables
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] dest;
    logic        pin;
    logic        wrt;
    logic        wrp;
  } bt_upd_t;

  // Sweep write that parks entry idx on a tag no fetch PC can match
  function automatic bt_upd_t clear_op(input logic [TAG_W-1:0] tag,
                                       input logic [INDEX_W-1:0] idx);
    bt_upd_t op;
    op.pc4  = {tag, idx, 2'b00};
    op.dest = '0;
    op.pin  = 1'b0;
    op.wrt  = 1'b1;
    op.wrp  = 1'b1;
    return op;
  endfunction

endpackage

// File: rtl/bt_upd_fifo.sv
// rtl/bt_upd_fifo.sv - small sync FIFO of pending table writes
module bt_upd_fifo
  import bt_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr_i,
  input  logic    push_i,
  input  bt_upd_t push_data_i,
  input  logic    pop_i,
  output bt_upd_t pop_data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  bt_upd_t     mem_q [QDEPTH];
  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;

  // Extra pointer bit separates full from empty when the indices match
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

  // Pointer update; push and pop may coincide, clear empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; the head is read before this edge, so full push+pop is safe
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/bt_update_ctrl.sv
// rtl/bt_update_ctrl.sv - branch resolution, redirect and table write arbitration
module bt_update_ctrl
  import bt_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter logic [TAG_W-1:0] INV_TAG = bt_pkg::INV_TAG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc4,
  input  logic        res_hit,
  input  logic        res_pred,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  input  logic        cfg_req,
  input  logic        cfg_clr,
  input  logic [31:0] cfg_pc4,
  input  logic [31:0] cfg_dest,
  input  logic        cfg_pred,
  input  logic        cfg_wr_tag,
  input  logic        cfg_wr_pred,
  output logic        cfg_gnt,
  output logic        bt_wrt,
  output logic        bt_wrp,
  output logic [31:0] bt_pc4d,
  output logic [31:0] bt_dest,
  output logic        bt_pin,
  output logic        init_done
);

  bt_state_e          state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;

  logic        flush_q, cfg_gnt_q, init_done_q;
  logic [31:0] redirect_q;
  logic        bt_wrt_q, bt_wrp_q, bt_pin_q;
  logic [31:0] bt_pc4d_q, bt_dest_q;

  logic    fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  bt_upd_t fifo_head, new_op, wr_op;
  logic    wr_en;

  logic run, accept, mispredict, enq, cfg_grant, clr_grant;

  assign run        = (state_q == RUN);
  // The head always drains in RUN, so a full queue still accepts
  assign res_ready  = init_done_q & (~fifo_full | ~fifo_empty);
  assign accept     = res_valid & res_ready;
  assign mispredict = ((res_hit & res_pred) != res_taken);
  assign enq        = accept & (res_hit ? mispredict : res_taken);
  assign cfg_grant  = run & cfg_req & ~cfg_gnt_q & fifo_empty & ~enq;
  assign clr_grant  = cfg_grant & cfg_clr;

  // Hits only flip the prediction bit; taken misses allocate a new entry
  always_comb begin
    new_op.pc4  = res_pc4;
    new_op.dest = res_target;
    new_op.pin  = res_hit ? res_taken : 1'b1;
    new_op.wrt  = ~res_hit;
    new_op.wrp  = 1'b1;
  end

  bt_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (fifo_clr),
    .push_i     (fifo_push),
    .push_data_i(new_op),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // State register: sweep phase and sweep index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: sweep all entries once, restart the sweep on a clear grant
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + INDEX_W'(1);
      if (idx_q == '1) state_d = RUN;
    end else if (clr_grant) begin
      state_d = CLEAR;
      idx_d   = '0;
    end
  end

  // Write selection: sweep, else queue head, else fresh op straight through, else config
  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    wr_en     = 1'b0;
    wr_op     = '0;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
      wr_op = clear_op(INV_TAG, idx_q);
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      fifo_push = enq;
      wr_en     = 1'b1;
      wr_op     = fifo_head;
    end else if (enq) begin
      wr_en = 1'b1;
      wr_op = new_op;
    end else if (cfg_grant) begin
      if (cfg_clr) begin
        fifo_clr = 1'b1;
      end else begin
        wr_en      = 1'b1;
        wr_op.pc4  = cfg_pc4;
        wr_op.dest = cfg_dest;
        wr_op.pin  = cfg_pred;
        wr_op.wrt  = cfg_wr_tag;
        wr_op.wrp  = cfg_wr_pred;
      end
    end
  end

  // Output registers: enables pulse, write data holds between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_wrt_q    <= 1'b0;
      bt_wrp_q    <= 1'b0;
      bt_pin_q    <= 1'b0;
      bt_pc4d_q   <= '0;
      bt_dest_q   <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      cfg_gnt_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      bt_wrt_q <= wr_en & wr_op.wrt;
      bt_wrp_q <= wr_en & wr_op.wrp;
      if (wr_en) begin
        bt_pc4d_q <= wr_op.pc4;
        bt_dest_q <= wr_op.dest;
        bt_pin_q  <= wr_op.pin;
      end
      flush_q <= accept & mispredict;
      if (accept & mispredict) redirect_q <= res_taken ? res_target : res_pc4;
      cfg_gnt_q   <= cfg_grant;
      // Rises one cycle after the last sweep write is presented
      init_done_q <= (state_q == RUN) & (state_d == RUN);
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign cfg_gnt     = cfg_gnt_q;
  assign bt_wrt      = bt_wrt_q;
  assign bt_wrp      = bt_wrp_q;
  assign bt_pc4d     = bt_pc4d_q;
  assign bt_dest     = bt_dest_q;
  assign bt_pin      = bt_pin_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_bt_update_ctrl.sv
// tb/tb_bt_update_ctrl.sv - directed self-checking bench for bt_update_ctrl
module tb_bt_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid, res_ready;
  logic [31:0] res_pc4, res_target;
  logic        res_hit, res_pred, res_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        cfg_req, cfg_clr, cfg_pred, cfg_wr_tag, cfg_wr_pred, cfg_gnt;
  logic [31:0] cfg_pc4, cfg_dest;
  logic        bt_wrt, bt_wrp, bt_pin, init_done;
  logic [31:0] bt_pc4d, bt_dest;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bt_update_ctrl #(.QDEPTH(2), .INV_TAG(26'h3FFFFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc4(res_pc4),
    .res_hit(res_hit), .res_pred(res_pred), .res_taken(res_taken),
    .res_target(res_target), .flush(flush), .redirect_pc(redirect_pc),
    .cfg_req(cfg_req), .cfg_clr(cfg_clr), .cfg_pc4(cfg_pc4), .cfg_dest(cfg_dest),
    .cfg_pred(cfg_pred), .cfg_wr_tag(cfg_wr_tag), .cfg_wr_pred(cfg_wr_pred),
    .cfg_gnt(cfg_gnt), .bt_wrt(bt_wrt), .bt_wrp(bt_wrp), .bt_pc4d(bt_pc4d),
    .bt_dest(bt_dest), .bt_pin(bt_pin), .init_done(init_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] pc4, input logic hit, input logic pred,
                           input logic taken, input logic [31:0] tgt);
    res_pc4 = pc4; res_hit = hit; res_pred = pred; res_taken = taken;
    res_target = tgt; res_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    step(); step();
    total++;
    if ({bt_wrt, bt_wrp, flush, cfg_gnt, res_ready, init_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {bt_wrt, bt_wrp, flush, cfg_gnt, res_ready, init_done});
    end
    total++;
    if ({bt_pc4d, bt_dest, redirect_pc, bt_pin} !== 97'b0) begin
      bad++;
      $display("FAIL reset_data got pc4d=%h dest=%h redir=%h exp=0", bt_pc4d, bt_dest, redirect_pc);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp = 32'hFFFFFFC0 + 32'(i * 4);
      total++;
      if ({bt_wrt, bt_wrp, init_done, res_ready} !== 4'b1100 || bt_pc4d !== exp ||
          bt_dest !== 32'h0 || bt_pin !== 1'b0) begin
        bad++;
        $display("FAIL sweep_%0d got ctl=%b pc4d=%h exp ctl=1100 pc4d=%h", i,
                 {bt_wrt, bt_wrp, init_done, res_ready}, bt_pc4d, exp);
      end
    end
    step();
    total++;
    if ({bt_wrt, bt_wrp, init_done, res_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL sweep_done got ctl=%b exp=0011", {bt_wrt, bt_wrp, init_done, res_ready});
    end
  endtask

  task automatic test_miss_taken();
    total++;
    if (res_ready !== 1'b1) begin bad++; $display("FAIL mt_ready got=%b exp=1", res_ready); end
    drive_res(32'h104, 1'b0, 1'b0, 1'b1, 32'h200);
    step();
    res_valid = 1'b0;
    total++;
    if (flush !== 1'b1 || redirect_pc !== 32'h200) begin
      bad++;
      $display("FAIL mt_flush got flush=%b redir=%h exp 1 00000200", flush, redirect_pc);
    end
    total++;
    if ({bt_wrt, bt_wrp, bt_pin} !== 3'b111 || bt_pc4d !== 32'h104 || bt_dest !== 32'h200) begin
      bad++;
      $display("FAIL mt_write got en=%b pc4d=%h dest=%h exp 111 00000104 00000200",
               {bt_wrt, bt_wrp, bt_pin}, bt_pc4d, bt_dest);
    end
    step();
    total++;
    if ({flush, bt_wrt, bt_wrp} !== 3'b000 || bt_pc4d !== 32'h104 || bt_dest !== 32'h200) begin
      bad++;
      $display("FAIL mt_idle got ctl=%b pc4d=%h dest=%h exp 000 00000104 00000200",
               {flush, bt_wrt, bt_wrp}, bt_pc4d, bt_dest);
    end
  endtask

  task automatic test_miss_not_taken();
    drive_res(32'h208, 1'b0, 1'b0, 1'b0, 32'h999);
    step();
    res_valid = 1'b0;
    total++;
    if ({flush, bt_wrt, bt_wrp} !== 3'b000 || bt_pc4d !== 32'h104) begin
      bad++;
      $display("FAIL mnt got ctl=%b pc4d=%h exp 000 00000104", {flush, bt_wrt, bt_wrp}, bt_pc4d);
    end
  endtask

  task automatic test_hit_mispredict();
    drive_res(32'h104, 1'b1, 1'b1, 1'b0, 32'h200);
    step();
    res_valid = 1'b0;
    total++;
    if (flush !== 1'b1 || redirect_pc !== 32'h104) begin
      bad++;
      $display("FAIL hm_flush got flush=%b redir=%h exp 1 00000104", flush, redirect_pc);
    end
    total++;
    if ({bt_wrt, bt_wrp, bt_pin} !== 3'b010 || bt_pc4d !== 32'h104) begin
      bad++;
      $display("FAIL hm_write got en=%b pc4d=%h exp 010 00000104", {bt_wrt, bt_wrp, bt_pin}, bt_pc4d);
    end
  endtask

  task automatic test_hit_correct();
    drive_res(32'h104, 1'b1, 1'b1, 1'b1, 32'h200);
    step();
    res_valid = 1'b0;
    total++;
    if ({flush, bt_wrt, bt_wrp, bt_pin} !== 4'b0000) begin
      bad++;
      $display("FAIL hc got ctl=%b exp=0000", {flush, bt_wrt, bt_wrp, bt_pin});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v_pc [4];
    logic [31:0] v_tg [4];
    logic [2:0]  v_hpt [4];
    logic [31:0] e_redir [4];
    logic [2:0]  e_wr [4];
    v_pc[0] = 32'h10; v_tg[0] = 32'h80; v_hpt[0] = 3'b001; e_redir[0] = 32'h80; e_wr[0] = 3'b111;
    v_pc[1] = 32'h14; v_tg[1] = 32'h84; v_hpt[1] = 3'b110; e_redir[1] = 32'h14; e_wr[1] = 3'b010;
    v_pc[2] = 32'h18; v_tg[2] = 32'h90; v_hpt[2] = 3'b101; e_redir[2] = 32'h90; e_wr[2] = 3'b011;
    v_pc[3] = 32'h1C; v_tg[3] = 32'hA0; v_hpt[3] = 3'b001; e_redir[3] = 32'hA0; e_wr[3] = 3'b111;
    cfg_req = 1'b1; cfg_clr = 1'b0; cfg_pc4 = 32'h300; cfg_dest = 32'h400;
    cfg_pred = 1'b1; cfg_wr_tag = 1'b1; cfg_wr_pred = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_res(v_pc[k], v_hpt[k][2], v_hpt[k][1], v_hpt[k][0], v_tg[k]);
      total++;
      if (res_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", k, res_ready); end
      step();
      total++;
      if (flush !== 1'b1 || redirect_pc !== e_redir[k] || cfg_gnt !== 1'b0 ||
          {bt_wrt, bt_wrp, bt_pin} !== e_wr[k] || bt_pc4d !== v_pc[k]) begin
        bad++;
        $display("FAIL b2b_%0d got fl=%b redir=%h gnt=%b en=%b pc4d=%h exp 1 %h 0 %b %h", k,
                 flush, redirect_pc, cfg_gnt, {bt_wrt, bt_wrp, bt_pin}, bt_pc4d,
                 e_redir[k], e_wr[k], v_pc[k]);
      end
    end
    res_valid = 1'b0;
    step();
    total++;
    if ({cfg_gnt, bt_wrt, bt_wrp, bt_pin, flush} !== 5'b11110 || bt_pc4d !== 32'h300 ||
        bt_dest !== 32'h400) begin
      bad++;
      $display("FAIL b2b_cfg got ctl=%b pc4d=%h dest=%h exp 11110 00000300 00000400",
               {cfg_gnt, bt_wrt, bt_wrp, bt_pin, flush}, bt_pc4d, bt_dest);
    end
    cfg_req = 1'b0;
    step();
    total++;
    if ({cfg_gnt, bt_wrt, bt_wrp} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_cfg_end got ctl=%b exp=000", {cfg_gnt, bt_wrt, bt_wrp});
    end
  endtask

  task automatic test_cfg_clr();
    logic [31:0] exp;
    cfg_req = 1'b1; cfg_clr = 1'b1;
    drive_res(32'h40, 1'b0, 1'b0, 1'b1, 32'h50);
    step();
    res_valid = 1'b0;
    total++;
    if ({bt_wrt, bt_wrp, cfg_gnt, init_done} !== 4'b1101 || bt_pc4d !== 32'h40 || bt_dest !== 32'h50) begin
      bad++;
      $display("FAIL clr_entry got ctl=%b pc4d=%h dest=%h exp 1101 00000040 00000050",
               {bt_wrt, bt_wrp, cfg_gnt, init_done}, bt_pc4d, bt_dest);
    end
    step();
    total++;
    if ({cfg_gnt, bt_wrt, bt_wrp, init_done, res_ready} !== 5'b10000) begin
      bad++;
      $display("FAIL clr_gnt got ctl=%b exp=10000", {cfg_gnt, bt_wrt, bt_wrp, init_done, res_ready});
    end
    cfg_req = 1'b0; cfg_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp = 32'hFFFFFFC0 + 32'(i * 4);
      total++;
      if ({bt_wrt, bt_wrp, init_done, res_ready} !== 4'b1100 || bt_pc4d !== exp) begin
        bad++;
        $display("FAIL clr_sweep_%0d got ctl=%b pc4d=%h exp 1100 %h", i,
                 {bt_wrt, bt_wrp, init_done, res_ready}, bt_pc4d, exp);
      end
    end
    step();
    total++;
    if ({bt_wrt, init_done, res_ready} !== 3'b011) begin
      bad++;
      $display("FAIL clr_done got ctl=%b exp=011", {bt_wrt, init_done, res_ready});
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] exp;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cfg_req = 1'b1; cfg_clr = 1'b0; cfg_pc4 = 32'h500; cfg_dest = 32'h600;
    cfg_pred = 1'b0; cfg_wr_tag = 1'b1; cfg_wr_pred = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++;
    if (bt_pc4d !== 32'hFFFFFFDC || bt_wrt !== 1'b1) begin
      bad++;
      $display("FAIL mid_idx7 got wrt=%b pc4d=%h exp 1 ffffffdc", bt_wrt, bt_pc4d);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bt_wrt, bt_wrp, flush, cfg_gnt, res_ready, init_done} !== 6'b0 || bt_pc4d !== 32'h0) begin
      bad++;
      $display("FAIL mid_async got ctl=%b pc4d=%h exp 000000 00000000",
               {bt_wrt, bt_wrp, flush, cfg_gnt, res_ready, init_done}, bt_pc4d);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp = 32'hFFFFFFC0 + 32'(i * 4);
      total++;
      if ({bt_wrt, bt_wrp, cfg_gnt, init_done} !== 4'b1100 || bt_pc4d !== exp) begin
        bad++;
        $display("FAIL mid_sweep_%0d got ctl=%b pc4d=%h exp 1100 %h", i,
                 {bt_wrt, bt_wrp, cfg_gnt, init_done}, bt_pc4d, exp);
      end
    end
    step();
    total++;
    if ({cfg_gnt, bt_wrt, bt_wrp, bt_pin, init_done} !== 5'b11001 || bt_pc4d !== 32'h500 ||
        bt_dest !== 32'h600) begin
      bad++;
      $display("FAIL mid_cfg got ctl=%b pc4d=%h dest=%h exp 11001 00000500 00000600",
               {cfg_gnt, bt_wrt, bt_wrp, bt_pin, init_done}, bt_pc4d, bt_dest);
    end
    cfg_req = 1'b0;
    step();
    total++;
    if ({cfg_gnt, bt_wrt} !== 2'b00) begin
      bad++;
      $display("FAIL mid_cfg_end got ctl=%b exp=00", {cfg_gnt, bt_wrt});
    end
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_pc4 = '0; res_hit = 1'b0; res_pred = 1'b0;
    res_taken = 1'b0; res_target = '0; cfg_req = 1'b0; cfg_clr = 1'b0; cfg_pc4 = '0;
    cfg_dest = '0; cfg_pred = 1'b0; cfg_wr_tag = 1'b0; cfg_wr_pred = 1'b0;
    test_reset();
    test_miss_taken();
    test_miss_not_taken();
    test_hit_mispredict();
    test_hit_correct();
    test_back_to_back();
    test_cfg_clr();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_update_ctrl.md
# bt_update_ctrl

Update controller and write-port arbiter for the 16-entry 1-bit branch table. It accepts resolved branches from EX and computes mispredict/redirect. It queues table updates and serialises them with a configuration/debug write port onto the table's single write interface (tag/dest write plus prediction-bit write). After reset it sweeps every entry to an invalid tag so that no stale hit can occur.

## Interface
- QDEPTH, 2, update queue depth (power of 2, ≥2)
- INV_TAG, 26'h3FFFFFF, tag value written during clear sweep
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- res_valid  in  1  EX resolution valid
- res_ready  out  1  queue not full; resolution accepted when res_valid & res_ready
- res_pc4  in  32  PC+4 of resolved branch
- res_hit  in  1  table hit at fetch
- res_pred  in  1  prediction used at fetch (0 if miss)
- res_taken  in  1  actual outcome
- res_target  in  32  actual target
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  32  correct fetch PC, valid with flush
- cfg_req  in  1  config write request (level, held until cfg_gnt)
- cfg_clr  in  1  with cfg_req: restart clear sweep instead of a write
- cfg_pc4, cfg_dest  in  32  config entry address / target
- cfg_pred, cfg_wr_tag, cfg_wr_pred  in  1  config prediction bit / write enables
- cfg_gnt  out  1  one-cycle pulse: config write issued this cycle
- bt_wrt, bt_wrp  out  1  table tag+dest / prediction write enables
- bt_pc4d, bt_dest  out  32  table write address (PC+4) / target
- bt_pin  out  1  table prediction bit
- init_done  out  1  high when not sweeping

## Operation
- States: CLEAR, RUN. Reset → CLEAR with idx=0.
- CLEAR: each cycle, bt_wrt=bt_wrp=1, bt_pc4d={INV_TAG, idx, 2'b00}, bt_dest=0, bt_pin=0; idx++. After idx=15 is written → RUN. 16 write cycles. res_ready=0, cfg_gnt=0, init_done=0.
- RUN, on accepted resolution:
  - mispredict = (res_hit & res_pred) != res_taken.
  - If mispredict: flush=1 next cycle, redirect_pc = res_taken ? res_target : res_pc4.
  - Enqueue op:
    - hit: prediction update (wrp, pin=res_taken), only if mispredict.
    - miss & taken: allocate (wrt+wrp, dest=res_target, pin=1).
    - miss & not taken: no enqueue.
- Write issue priority each RUN cycle: queue head > config. At most one table write per cycle.
- Config:
  - granted only if queue empty and no enqueue this cycle.
  - cfg_clr grant → CLEAR, idx=0, clears queue.
  - Otherwise drives bt_wrt=cfg_wr_tag, bt_wrp=cfg_wr_pred, pc4d/dest/pin from cfg.
- Known limitation: the target of a taken hit is not checked (the table holds one target per tag).

## Timing
- All outputs registered. Reset values: all outputs 0, except res_ready=0 and init_done=0 until CLEAR completes.
- Resolution accepted at edge N:
  - flush/redirect_pc valid during cycle N+1.
  - Table write no earlier than cycle N+1 (queue-empty case exactly N+1).
- Queue: simultaneous enqueue and dequeue permitted when full, so res_ready = !full | dequeuing. Pointers wrap modulo QDEPTH.
- bt_wrt/bt_wrp are 1-cycle pulses per write; bt_pc4d/bt_dest/bt_pin hold their last value when no write occurs.
- Async reset mid-sweep or mid-queue: immediately returns to CLEAR, idx=0, queue empty, flush=0.
- cfg_req during CLEAR is held off; it is granted in RUN as soon as the queue is idle.

## Structure
- Package bt_pkg: state enum {CLEAR, RUN}, INDEX_W=4, TAG_W=26, INV_TAG, and queue entry struct {pc4[31:0], dest[31:0], pin, wrt, wrp}.
- One sub-module: bt_upd_fifo (parameterised QDEPTH sync FIFO holding the entry struct, with full/empty flags and same-cycle push/pop).

## Test plan
- Reset then run: exactly 16 consecutive cycles with bt_wrt=bt_wrp=1, bt_pc4d=FFFFFFC0, FFFFFFC4 … FFFFFFFC. init_done rises after the 16th write; res_ready=1.
- Miss, taken: res_pc4=00000104, target=00000200 → cycle after acceptance flush=1, redirect=00000200. Same cycle: bt_wrt=bt_wrp=1, bt_pc4d=00000104, bt_dest=00000200, bt_pin=1.
- Hit with pred=1, not taken at 00000104 → flush=1, redirect=00000104; bt_wrp only, bt_pin=0. Hit pred=1, taken → no flush, no write.
- Back-to-back mispredicts every cycle with cfg_req held: writes issue one per cycle in order and res_ready never drops. cfg_gnt occurs only on the first cycle with the queue empty.
- cfg_req+cfg_clr in RUN with 1 queued entry: the entry is written first, then a full 16-cycle sweep. init_done=0 throughout the sweep.
- rst_n asserted at sweep idx=7: outputs go to 0 immediately; after release the sweep restarts at idx=0.
